// File: rtl/regfile_dump_unit.sv
// -----------------------------------------------------------------------------
// regfile_dump_unit
//
// Purpose
//   Sits behind the multi-cycle RISC-V core. It waits for the core's
//   program-complete flag, or for a watchdog timeout if the program never
//   finishes. It then reads the 32 architectural registers in order through
//   the core's register-file read port and streams them out over a
//   valid/ready interface. A 33rd beat carries the core's cycle count.
//   Benches read this stream instead of peeking into the core hierarchy.
//
// Parameters
//   DATA_W   register / stream data width
//   CNT_W    width of the core's clock_count output
//   TIMEOUT  cycles after reset release to wait for done before forcing a
//            dump (must be >= 2)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   done         in   core program-complete flag (level)
//   clock_count  in   core cycle counter, sampled once when the dump starts
//   rd_addr      out  register-file read address (registered)
//   rd_data      in   register-file read data, combinational from rd_addr
//   out_valid    out  stream beat valid
//   out_ready    in   downstream accepts the current beat
//   out_data     out  register value, or cycle count on the last beat
//   out_index    out  0..31 register number, 32 for the cycle-count record
//   out_last     out  high on the index-32 beat only
//   busy         out  high while capturing or streaming
//   dump_done    out  sticky: all 33 beats accepted
//   timed_out    out  sticky: the dump was forced by the watchdog
// -----------------------------------------------------------------------------
module regfile_dump_unit #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              done,
    input  logic [CNT_W-1:0]  clock_count,
    output logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic              dump_done,
    output logic              timed_out
);

    // The watchdog only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
    localparam int               WD_W     = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [5:0]       LAST_IDX = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STREAM,
        FINISH
    } state_t;

    state_t            state;
    logic [WD_W-1:0]   watchdog;
    logic [DATA_W-1:0] count_q;     // cycle count latched in CAPTURE
    logic [5:0]        next_n;      // next stream entry to load, 0..33

    logic [DATA_W-1:0] count_fit;
    logic [DATA_W-1:0] entry_data;
    logic              entry_last;
    logic              load_slot;
    logic              have_entry;
    logic              accept_last;

    // Fit the core's counter to the stream width: zero-extend a narrow
    // counter, keep the low DATA_W bits of a wide one.
    generate
        if (CNT_W >= DATA_W) begin : g_cnt_trunc
            assign count_fit = clock_count[DATA_W-1:0];
        end else begin : g_cnt_ext
            assign count_fit = {{(DATA_W - CNT_W){1'b0}}, clock_count};
        end
    endgenerate

    // The output register can take a new entry when it is empty or when
    // its current beat is being accepted in this cycle.
    assign load_slot   = !out_valid || out_ready;
    assign have_entry  = (next_n <= LAST_IDX);
    assign accept_last = out_valid && out_ready && out_last;

    // Pick the entry for the next load. Entries 0..31 come from the
    // register file, whose address already equals next_n. Entry 32 is the
    // latched cycle count.
    always_comb begin
        // NOTE: every always_comb output gets a default first. Without one,
        // a path that skips the assignment infers a latch.
        entry_data = rd_data;
        entry_last = 1'b0;
        if (next_n == LAST_IDX) begin
            entry_data = count_q;
            entry_last = 1'b1;
        end
    end

    // Control FSM and all registered outputs. rd_addr depends only on
    // state, so there is no combinational path from out_ready to the
    // register file.
    // NOTE: sequential state is written with non-blocking assignments.
    // This lets every register see the pre-edge values of the others,
    // whatever order the statements are in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            watchdog  <= '0;
            count_q   <= '0;
            next_n    <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    watchdog <= watchdog + 1'b1;
                    rd_addr  <= '0;
                    // done wins over a watchdog expiry in the same cycle,
                    // so timed_out stays clear in that case.
                    if (done) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end else if (watchdog == WD_LAST) begin
                        timed_out <= 1'b1;
                        state     <= CAPTURE;
                        busy      <= 1'b1;
                    end
                end

                CAPTURE: begin
                    // Later changes on clock_count are ignored.
                    count_q <= count_fit;
                    rd_addr <= '0;
                    next_n  <= '0;
                    busy    <= 1'b1;
                    state   <= STREAM;
                end

                STREAM: begin
                    if (accept_last) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        dump_done <= 1'b1;
                        state     <= FINISH;
                    end else if (load_slot && have_entry) begin
                        out_data  <= entry_data;
                        out_index <= next_n;
                        out_last  <= entry_last;
                        out_valid <= 1'b1;
                        next_n    <= next_n + 6'd1;
                        // Set up the read for the following entry. It wraps
                        // to 0 after register 31, and the count beat does
                        // not use it.
                        rd_addr   <= 5'(next_n + 6'd1);
                    end else if (load_slot && !have_entry && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    // With no load, the output register holds its value.
                    // This keeps the beat stable while it is stalled.
                end

                FINISH: begin
                    // Terminal until reset. done cannot start another dump.
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    dump_done <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_unit
//
// Self-checking bench for regfile_dump_unit (TIMEOUT = 50). A register-file
// array in the bench answers the read port. Each dump is checked against an
// expected list of 33 values: the 32 register values in order, then the
// cycle count.
// -----------------------------------------------------------------------------
module tb_regfile_dump_unit;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 50;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              done = 1'b0;
    logic [CNT_W-1:0]  clock_count = '0;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [5:0]        out_index;
    logic              out_last;
    logic              busy;
    logic              dump_done;
    logic              timed_out;

    logic [DATA_W-1:0] regs [32];

    int checks = 0;
    int errors = 0;

    assign rd_data = regs[rd_addr];

    always #5 clock = ~clock;

    regfile_dump_unit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .done       (done),
        .clock_count(clock_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .dump_done  (dump_done),
        .timed_out  (timed_out)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Assert reset at the sampling phase and check the reset values.
    // Release it two cycles later. Cycle 0 of the next run is this release.
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset     = 1'b1;
        done      = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  dump_done, 0);
        check("rst_to",    timed_out, 0);
        check("rst_addr",  rd_addr, 0);
        check("rst_data",  {out_index, out_last, out_data}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Runs one dump and checks it against the expected list.
    //   mode      0: ready held high, 1: ready 1,0,0,1 repeating, 2: random
    //   done_at   cycle after release at which done is raised (-1: caller's choice)
    //   exp_busy  expected first cycle with busy high (-1: not checked)
    //   abort_at  if > 0, assert reset once this many beats are accepted
    task automatic run_dump(input int mode, input int done_at, input int exp_busy,
                            input logic exp_to, input logic [DATA_W-1:0] cnt,
                            input int abort_at);
        logic [DATA_W-1:0] exp_list [33];
        int cyc = 0, acc = 0, k = 0;
        int busy_cyc = -1, valid_cyc = -1, first_acc = -1, last_acc = -1;
        bit stall = 0, last_seen = 0, finished = 0;
        logic [DATA_W-1:0] h_data = '0;
        logic [5:0]        h_idx = '0;
        logic              h_last = 1'b0;

        for (int i = 0; i < 32; i++) exp_list[i] = regs[i];
        exp_list[32] = cnt;
        clock_count  = cnt;

        while (cyc < 400 && !finished) begin
            @(posedge clock);
            #1;
            cyc++;
            if (done_at >= 0 && cyc == done_at) done = 1'b1;
            // After the capture cycle, disturb both inputs. The dump must ignore them.
            if (busy_cyc >= 0 && cyc > busy_cyc) begin
                clock_count = $urandom;
                if (mode == 2) done = 1'($urandom);
            end
            if (last_seen) begin
                check("post_done",  dump_done, 1);
                check("post_valid", out_valid, 0);
                check("post_busy",  busy, 0);
                finished = 1;
            end else begin
                if (busy && busy_cyc < 0) busy_cyc = cyc;
                if (out_valid && valid_cyc < 0) valid_cyc = cyc;
                if (stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_hold", {out_last, out_index, out_data}, {h_last, h_idx, h_data});
                end
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                    default: out_ready = 1'($urandom);
                endcase
                k++;
                if (out_valid && out_ready) begin
                    if (acc > 32) begin
                        check("extra_beat", acc, 32);
                    end else begin
                        check("beat_index", out_index, acc);
                        check("beat_data",  out_data, exp_list[acc]);
                        check("beat_last",  out_last, (acc == 32));
                    end
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    if (out_last) last_seen = 1;
                    acc++;
                    if (abort_at > 0 && acc == abort_at) begin
                        @(posedge clock);
                        #1;
                        reset = 1'b1;
                        #1;
                        check("abort_valid", out_valid, 0);
                        check("abort_busy",  busy, 0);
                        check("abort_done",  dump_done, 0);
                        return;
                    end
                end
                stall  = out_valid && !out_ready;
                h_data = out_data;
                h_idx  = out_index;
                h_last = out_last;
            end
        end

        check("dump_finished", finished, 1);
        check("accept_count",  acc, 33);
        if (exp_busy >= 0) check("capture_cycle", busy_cyc, exp_busy);
        check("first_beat_latency", valid_cyc - busy_cyc, 2);
        check("timed_out", timed_out, exp_to);
        if (mode == 0) check("back_to_back", last_acc - first_acc, 32);
    endtask

    initial begin
        int quiet_bad;
        int sticky_bad;

        // Test 1: regs = i*3, done raised at cycle 20, count 57, ready held high.
        for (int i = 0; i < 32; i++) regs[i] = DATA_W'(i * 3);
        do_reset();
        run_dump(0, 20, 21, 1'b0, 57, 0);

        // done held high for 100 cycles, then toggled randomly for 100 more:
        // no second dump, dump_done stays set.
        done       = 1'b1;
        quiet_bad  = 0;
        sticky_bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            #1;
            if (c >= 100) done = 1'($urandom);
            out_ready = 1'($urandom);
            if (out_valid || busy) quiet_bad++;
            if (!dump_done) sticky_bad++;
        end
        check("no_redump", quiet_bad, 0);
        check("dump_done_sticky", sticky_bad, 0);

        // Test 2: random registers, ready pattern 1,0,0,1.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        do_reset();
        run_dump(1, 20, 21, 1'b0, $urandom, 0);

        // Test 3: done never raised, so the watchdog forces the dump (random ready).
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        do_reset();
        run_dump(2, -1, TIMEOUT, 1'b1, $urandom, 0);

        // Test 4: done first seen in the cycle the watchdog expires. done wins.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        do_reset();
        run_dump(2, TIMEOUT - 1, TIMEOUT, 1'b0, $urandom, 0);

        // Test 5: reset after 10 accepted beats. Then a fresh dump with done already high.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        do_reset();
        run_dump(0, 3, 4, 1'b0, $urandom, 10);
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        done = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        run_dump(2, -1, 1, 1'b0, $urandom, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Last-resort bound on run time if anything above stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
